mcpu_dualport_ram_ctrl: RTL and testbench
=========================================

// Module: mcpu_dualport_ram_ctrl
// PURPOSE
//  Clocked MCPU RAM controller: one single-ported word array shared by a data port (rd/wr)
//  and an instruction-fetch port (rd only). One access per cycle, req/ack handshake per port,
//  configurable arbitration. Sits between MCPU core load/store + fetch units and the RAM array.
// PARAMETERS
//  WORD_SIZE      8                  data word width (bits)
//  ADDR_WIDTH     8                  address width on both ports
//  RAM_SIZE       1<<ADDR_WIDTH      words implemented; must be <= 2**ADDR_WIDTH
//  DATA_PRIORITY  1                  1: data port wins ties; 0: round-robin between ports
// PORTS
//  clk        in   1           clock, all logic on rising edge
//  reset      in   1           synchronous reset, active-high
//  d_req      in   1           data request; held with d_we/d_addr/d_wdata stable until d_ack
//  d_we       in   1           1 = write, 0 = read
//  d_addr     in   ADDR_WIDTH  data address
//  d_wdata    in   WORD_SIZE   write data
//  d_ack      out  1           1-cycle pulse: data access complete
//  d_rdata    out  WORD_SIZE   read data, valid when d_ack on a read
//  i_req      in   1           instruction fetch request; held with i_addr stable until i_ack
//  i_addr     in   ADDR_WIDTH  fetch address
//  i_ack      out  1           1-cycle pulse: fetch complete
//  i_rdata    out  WORD_SIZE   fetched word, valid when i_ack
//  par_err    out  1           parity error, pulses with the ack of the failing read
// BEHAVIOUR
//  - Reset: d_ack=0, i_ack=0, d_rdata=0, i_rdata=0, par_err=0, last_grant=INSTR. Array
//    contents not cleared. Requests pending at reset are dropped (no ack); a req still high
//    after reset deasserts is a new request.
//  - Eligible: port req=1 and that port's ack=0 this cycle (req in the ack cycle is the
//    completed request; requester drops req or presents the next one from the following cycle).
//  - Arbiter (per cycle): only one eligible -> grant it. Both eligible: DATA_PRIORITY=1 ->
//    DATA; DATA_PRIORITY=0 -> port not equal to last_grant. last_grant updates on each grant.
//  - Grant in cycle N: array access at the edge ending N; ack + rdata registered, visible in
//    N+1. Latency 1 cycle. Per-port throughput 1 access / 2 cycles; array can be busy every
//    cycle with interleaved ports.
//  - Write: mem[d_addr] <= d_wdata; d_ack pulses; d_rdata holds its previous value.
//  - Read: rdata = mem[addr] as of the access edge; a write granted in N is seen by any read
//    granted in N+1 or later (no same-cycle conflict: single access per cycle).
//  - d_rdata / i_rdata hold last read value between acks.
//  - addr >= RAM_SIZE: write discarded, read returns 0, ack still given, par_err=0.
//  - Starvation: with DATA_PRIORITY=1 the data port can delay fetches only while it re-requests
//    back-to-back; its ack cycle always leaves a free slot, so i_req waits at most 1 cycle.
//  - Array register named mem[0:RAM_SIZE-1] (bench uses hierarchical access).
// CONFIGURATION
//  MCPU_RAM_PARITY_EN defined: mem words are WORD_SIZE+1 bits; even parity bit computed and
//   stored on every write; each in-range read checks parity, mismatch -> par_err=1 in the ack
//   cycle (data still returned). Reads of never-written words are not checked reliably.
//  Not defined: mem is WORD_SIZE bits, no parity logic, par_err tied 0.
// TESTING
//  1. reset=1 2 cycles with d_req=1,i_req=1 -> d_ack=i_ack=0, d_rdata=i_rdata=0, par_err=0.
//  2. write 0xA5 @0x10 (granted N) -> d_ack=1 N+1; read @0x10 -> d_ack, d_rdata=0xA5.
//  3. DATA_PRIORITY=1, d_req rd @0x10 + i_req @0x10 same cycle N -> d_ack N+1, i_ack N+2,
//     both rdata=0xA5.
//  4. DATA_PRIORITY=0, both reqs re-issued continuously -> grants alternate D,I,D,I; each port
//     acked every 2 cycles.
//  5. write 0x3C @0x20 granted N, i_req @0x20 granted N+1 -> i_ack N+2, i_rdata=0x3C.
//  6. RAM_SIZE=200: write 0x77 @0xF0 then read @0xF0 -> ack, d_rdata=0x00.
//  7. MCPU_RAM_PARITY_EN: write 0x01 @0x05, flip mem[5][0] hierarchically, read @0x05 ->
//     d_rdata=0x00, par_err=1 with d_ack; macro undefined -> par_err stays 0.

Source files
------------

// File: rtl/mcpu_dualport_ram_ctrl.sv
// MCPU RAM controller: one single-ported word array shared by a data port and a fetch port.
// Optional parity protection of stored words when MCPU_RAM_PARITY_EN is defined.
module mcpu_dualport_ram_ctrl #(
  parameter int unsigned WORD_SIZE     = 8,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned RAM_SIZE      = 1 << ADDR_WIDTH,
  parameter bit          DATA_PRIORITY = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WORD_SIZE-1:0]  d_wdata,
  output logic                  d_ack,
  output logic [WORD_SIZE-1:0]  d_rdata,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [WORD_SIZE-1:0]  i_rdata,
  output logic                  par_err
);

`ifdef MCPU_RAM_PARITY_EN
  localparam int unsigned MEM_W = WORD_SIZE + 1;
`else
  localparam int unsigned MEM_W = WORD_SIZE;
`endif
  localparam int unsigned IDX_W = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;

  typedef enum logic {GNT_DATA = 1'b0, GNT_INSTR = 1'b1} grant_t;

  grant_t                last_grant, last_grant_nxt;
  logic                  d_elig, i_elig, gnt_d, gnt_i;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [IDX_W-1:0]      acc_idx;
  logic                  in_range, wr_en;
  logic [MEM_W-1:0]      rd_word, wr_word;
  logic [WORD_SIZE-1:0]  rd_data;
  logic                  perr_c;

  logic [MEM_W-1:0] mem [0:RAM_SIZE-1];

  // A port in its ack cycle is presenting the request it just completed
  assign d_elig = d_req & ~d_ack;
  assign i_elig = i_req & ~i_ack;

  // Arbiter: one grant per cycle, tie broken by priority or round-robin
  always_comb begin
    gnt_d          = 1'b0;
    gnt_i          = 1'b0;
    last_grant_nxt = last_grant;
    if (d_elig && i_elig) begin
      if (DATA_PRIORITY || (last_grant == GNT_INSTR)) gnt_d = 1'b1;
      else                                            gnt_i = 1'b1;
    end else if (d_elig) begin
      gnt_d = 1'b1;
    end else if (i_elig) begin
      gnt_i = 1'b1;
    end
    if (gnt_d)      last_grant_nxt = GNT_DATA;
    else if (gnt_i) last_grant_nxt = GNT_INSTR;
  end

  always_ff @(posedge clk) begin
    if (reset) last_grant <= GNT_INSTR;
    else       last_grant <= last_grant_nxt;
  end

  assign acc_addr = gnt_d ? d_addr : i_addr;
  assign acc_idx  = acc_addr[IDX_W-1:0];
  assign in_range = (32'(acc_addr) < RAM_SIZE);
  assign wr_en    = gnt_d & d_we & in_range & ~reset;
  assign rd_word  = mem[acc_idx];

`ifdef MCPU_RAM_PARITY_EN
  // Even parity: stored word including parity bit has an even number of ones
  assign wr_word = {^d_wdata, d_wdata};
  assign rd_data = rd_word[WORD_SIZE-1:0];
  assign perr_c  = in_range & (^rd_word);
`else
  assign wr_word = d_wdata;
  assign rd_data = rd_word;
  assign perr_c  = 1'b0;
`endif

  // Array is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[acc_idx] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_ack   <= 1'b0;
      i_ack   <= 1'b0;
      d_rdata <= '0;
      i_rdata <= '0;
      par_err <= 1'b0;
    end else begin
      d_ack   <= gnt_d;
      i_ack   <= gnt_i;
      par_err <= 1'b0;
      if (gnt_d && !d_we) begin
        d_rdata <= in_range ? rd_data : '0;
        par_err <= perr_c;
      end
      if (gnt_i) begin
        i_rdata <= in_range ? rd_data : '0;
        par_err <= perr_c;
      end
    end
  end

endmodule

// File: tb/tb_mcpu_dualport_ram_ctrl.sv
// Bench for mcpu_dualport_ram_ctrl: vector table plus scoreboard on the priority instance,
// hand sequences on a round-robin / reduced-size instance. Honours MCPU_RAM_PARITY_EN.
module tb_mcpu_dualport_ram_ctrl;

`ifdef MCPU_RAM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       d_req, d_we, d_ack, i_req, i_ack, par_err;
  logic [7:0] d_addr, d_wdata, d_rdata, i_addr, i_rdata;

  logic       r_d_req, r_d_we, r_d_ack, r_i_req, r_i_ack, r_par_err;
  logic [7:0] r_d_addr, r_d_wdata, r_d_rdata, r_i_addr, r_i_rdata;

  mcpu_dualport_ram_ctrl #(.WORD_SIZE(8), .ADDR_WIDTH(8), .RAM_SIZE(256), .DATA_PRIORITY(1'b1)) dut (
    .clk(clk), .reset(reset),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .par_err(par_err)
  );

  mcpu_dualport_ram_ctrl #(.WORD_SIZE(8), .ADDR_WIDTH(8), .RAM_SIZE(200), .DATA_PRIORITY(1'b0)) dut_rr (
    .clk(clk), .reset(reset),
    .d_req(r_d_req), .d_we(r_d_we), .d_addr(r_d_addr), .d_wdata(r_d_wdata),
    .d_ack(r_d_ack), .d_rdata(r_d_rdata),
    .i_req(r_i_req), .i_addr(r_i_addr), .i_ack(r_i_ack), .i_rdata(r_i_rdata),
    .par_err(r_par_err)
  );

  typedef struct {
    logic [7:0] rdata;
    logic       perr;
  } exp_t;

  typedef struct {
    logic       port;   // 0 = data, 1 = fetch
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;  // expected rdata of that port after the ack
  } vec_t;

  exp_t dq[$];
  exp_t iq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: each ack pops the expectation pushed when its request was issued
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (d_ack && i_ack) check("both_ack_same_cycle", 32'(1), 32'(0));
      if (d_ack) begin
        if (dq.size() == 0) check("d_ack_unexpected", 32'(1), 32'(0));
        else begin
          e = dq.pop_front();
          check("d_rdata", 32'(d_rdata), 32'(e.rdata));
          check("d_par_err", 32'(par_err), 32'(e.perr));
        end
      end
      if (i_ack) begin
        if (iq.size() == 0) check("i_ack_unexpected", 32'(1), 32'(0));
        else begin
          e = iq.pop_front();
          check("i_rdata", 32'(i_rdata), 32'(e.rdata));
          check("i_par_err", 32'(par_err), 32'(e.perr));
        end
      end
    end
  end

  task automatic d_issue(input logic we, input logic [7:0] a, input logic [7:0] wd,
                         input logic [7:0] er, input logic ep);
    exp_t e;
    e.rdata = er;
    e.perr  = ep;
    dq.push_back(e);
    d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
  endtask

  task automatic i_issue(input logic [7:0] a, input logic [7:0] er, input logic ep);
    exp_t e;
    e.rdata = er;
    e.perr  = ep;
    iq.push_back(e);
    i_addr = a; i_req = 1'b1;
  endtask

  task automatic d_wait();
    int n = 0;
    do begin @(negedge clk); n++; end while (!d_ack && n < 8);
    check("d_latency", 32'(n), 32'(1));
    d_req = 1'b0;
  endtask

  task automatic i_wait();
    int n = 0;
    do begin @(negedge clk); n++; end while (!i_ack && n < 8);
    check("i_latency", 32'(n), 32'(1));
    i_req = 1'b0;
  endtask

  task automatic r_d_op(input logic we, input logic [7:0] a, input logic [7:0] wd);
    int n = 0;
    r_d_we = we; r_d_addr = a; r_d_wdata = wd; r_d_req = 1'b1;
    do begin @(negedge clk); n++; end while (!r_d_ack && n < 8);
    check("rr_d_latency", 32'(n), 32'(1));
    r_d_req = 1'b0;
    @(negedge clk);
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 8'h10, 8'hA5, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
    vecs[2]  = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5};
    vecs[3]  = '{1'b0, 1'b1, 8'h11, 8'h5A, 8'hA5};
    vecs[4]  = '{1'b1, 1'b0, 8'h11, 8'h00, 8'h5A};
    vecs[5]  = '{1'b0, 1'b0, 8'h11, 8'h00, 8'h5A};
    vecs[6]  = '{1'b0, 1'b1, 8'hFF, 8'hC3, 8'h5A};
    vecs[7]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'hC3};
    vecs[8]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'hC3};
    vecs[9]  = '{1'b0, 1'b1, 8'h10, 8'h00, 8'hC3};
    vecs[10] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h00};

    reset = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h00; d_wdata = 8'h00;
    i_req = 1'b1; i_addr = 8'h00;
    r_d_req = 1'b1; r_d_we = 1'b0; r_d_addr = 8'h00; r_d_wdata = 8'h00;
    r_i_req = 1'b1; r_i_addr = 8'h00;

    // Reset with requests pending: nothing acked, outputs cleared
    repeat (2) @(negedge clk);
    check("rst_d_ack", 32'(d_ack), 32'(0));
    check("rst_i_ack", 32'(i_ack), 32'(0));
    check("rst_d_rdata", 32'(d_rdata), 32'(0));
    check("rst_i_rdata", 32'(i_rdata), 32'(0));
    check("rst_par_err", 32'(par_err), 32'(0));
    check("rst_rr_acks", 32'({r_d_ack, r_i_ack}), 32'(0));
    d_req = 1'b0; i_req = 1'b0; r_d_req = 1'b0; r_i_req = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Vector table: sequential single-port accesses
    for (int k = 0; k < 11; k++) begin
      if (vecs[k].port == 1'b0) begin
        d_issue(vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].rdata, 1'b0);
        d_wait();
      end else begin
        i_issue(vecs[k].addr, vecs[k].rdata, 1'b0);
        i_wait();
      end
      @(negedge clk);
    end

    // Simultaneous read requests: data wins, fetch served next cycle
    d_issue(1'b0, 8'h11, 8'h00, 8'h5A, 1'b0);
    i_issue(8'h11, 8'h5A, 1'b0);
    @(negedge clk);
    check("tie_first_data", 32'({d_ack, i_ack}), 32'(2'b10));
    d_req = 1'b0;
    @(negedge clk);
    check("tie_then_fetch", 32'({d_ack, i_ack}), 32'(2'b01));
    i_req = 1'b0;
    @(negedge clk);

    // Write then fetch of same word in next cycle sees new data
    d_issue(1'b1, 8'h20, 8'h3C, 8'h5A, 1'b0);
    i_issue(8'h20, 8'h3C, 1'b0);
    @(negedge clk);
    check("wr_first", 32'({d_ack, i_ack}), 32'(2'b10));
    d_req = 1'b0;
    @(negedge clk);
    check("fetch_after_wr", 32'({d_ack, i_ack}), 32'(2'b01));
    i_req = 1'b0;
    @(negedge clk);

    // Tie with last grant = data: fixed priority still picks data
    d_issue(1'b0, 8'h20, 8'h00, 8'h3C, 1'b0);
    d_wait();
    @(negedge clk);
    d_issue(1'b0, 8'h11, 8'h00, 8'h5A, 1'b0);
    i_issue(8'h20, 8'h3C, 1'b0);
    @(negedge clk);
    check("prio_after_data", 32'({d_ack, i_ack}), 32'(2'b10));
    d_req = 1'b0;
    @(negedge clk);
    check("prio_fetch_next", 32'({d_ack, i_ack}), 32'(2'b01));
    i_req = 1'b0;
    @(negedge clk);

    // Parity: corrupt stored data bit, read back on both ports
    d_issue(1'b1, 8'h05, 8'h01, 8'h5A, 1'b0);
    d_wait();
    @(negedge clk);
    dut.mem[5][0] = ~dut.mem[5][0];
    d_issue(1'b0, 8'h05, 8'h00, 8'h00, PAR);
    d_wait();
    @(negedge clk);
    i_issue(8'h05, 8'h00, PAR);
    i_wait();
    @(negedge clk);
    check("par_err_clears", 32'(par_err), 32'(0));
    d_issue(1'b1, 8'h05, 8'h81, 8'h00, 1'b0);
    d_wait();
    @(negedge clk);
    d_issue(1'b0, 8'h05, 8'h00, 8'h81, 1'b0);
    d_wait();
    @(negedge clk);
    check("queues_drained", 32'(dq.size() + iq.size()), 32'(0));

    // Round-robin instance: continuous requests alternate D,I,D,I
    r_d_we = 1'b1; r_d_addr = 8'h30; r_d_wdata = 8'h11; r_d_req = 1'b1;
    r_i_addr = 8'h30; r_i_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("rr_alt_%0d", k), 32'({r_d_ack, r_i_ack}),
            (k % 2 == 0) ? 32'(2'b10) : 32'(2'b01));
    end
    r_d_req = 1'b0; r_i_req = 1'b0;
    check("rr_fetch_data", 32'(r_i_rdata), 32'(8'h11));
    @(negedge clk);

    // Tie after a data grant: round-robin serves fetch first
    r_d_op(1'b0, 8'h30, 8'h00);
    check("rr_d_read", 32'(r_d_rdata), 32'(8'h11));
    r_d_we = 1'b0; r_d_addr = 8'h30; r_d_req = 1'b1;
    r_i_addr = 8'h30; r_i_req = 1'b1;
    @(negedge clk);
    check("rr_tie_fetch_first", 32'({r_d_ack, r_i_ack}), 32'(2'b01));
    r_i_req = 1'b0;
    @(negedge clk);
    check("rr_tie_data_next", 32'({r_d_ack, r_i_ack}), 32'(2'b10));
    r_d_req = 1'b0;
    @(negedge clk);

    // Reduced array: out-of-range writes dropped, reads return zero
    r_d_op(1'b1, 8'hF0, 8'h77);
    r_d_op(1'b0, 8'hF0, 8'h00);
    check("oor_rdata", 32'(r_d_rdata), 32'(0));
    check("oor_par_err", 32'(r_par_err), 32'(0));
    r_d_op(1'b1, 8'hC7, 8'h5E);
    r_d_op(1'b0, 8'hC7, 8'h00);
    check("last_in_range", 32'(r_d_rdata), 32'(8'h5E));
    r_d_op(1'b1, 8'hC8, 8'h99);
    r_d_op(1'b0, 8'hC8, 8'h00);
    check("first_oor", 32'(r_d_rdata), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
